// File: rtl/intt_stage_scheduler_pkg.sv
// Shared types and address arithmetic for the N=16 inverse-NTT stage scheduler.
// Gentleman-Sande ordering: stage s pairs j with j+2^s, twiddle from psi_inv[h+i].
package intt_stage_scheduler_pkg;

  localparam int LOG_N = 4;
  localparam int N     = 1 << LOG_N;
  localparam int Q     = 65537;
  localparam int AW    = LOG_N;
  localparam int SW    = $clog2(LOG_N);
  localparam int KW    = LOG_N - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_BARRIER,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] tw;
  } bf_addr_t;

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } wb_t;

  function automatic bf_addr_t bf_addr(
    input logic [SW-1:0] s,
    input logic [KW-1:0] k
  );
    logic [AW-1:0] t;
    logic [AW-1:0] i;
    logic [AW-1:0] off;
    logic [AW-1:0] j;
    bf_addr_t      r;
    t     = AW'(1) << s;
    i     = {1'b0, k} >> s;
    off   = {1'b0, k} & (t - AW'(1));
    j     = (i << (int'(s) + 1)) + off;
    r.a   = j;
    r.b   = j + t;
    r.tw  = AW'(N >> (int'(s) + 1)) + i;
    return r;
  endfunction

endpackage

// File: rtl/intt_stage_scheduler_delay_line.sv
// Stallable shift register carrying valid + write-back addresses to the
// write port; pend_valid flags entries that have not yet reached the output.
module ntt_delay_line #(
  parameter int W     = 9,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] in_d,
  output logic [W-1:0] out_q,
  output logic         pend_valid
);

  logic [W-1:0] pipe_q [DEPTH];
  logic [W-1:0] pipe_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i];
    end
    if (en) begin
      pipe_d[0] = in_d;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign out_q = pipe_q[DEPTH-1];

  // The entry at the output is being written back this cycle, so it
  // no longer blocks the next stage.
  always_comb begin
    pend_valid = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pend_valid = pend_valid | pipe_q[i][W-1];
    end
  end

endmodule

// File: rtl/intt_stage_scheduler.sv
// Issues one inverse-NTT butterfly per cycle and drains the butterfly
// pipeline between stages so no stage reads a coefficient still in flight.
module intt_stage_scheduler
  import intt_stage_scheduler_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic          bf_valid,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [AW-1:0] tw_addr,
  output logic [SW-1:0] stage,
  output logic          wb_valid,
  output logic [AW-1:0] wr_addr_a,
  output logic [AW-1:0] wr_addr_b
);

  state_e        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [KW-1:0] k_q, k_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bfv_q, bfv_d;
  bf_addr_t      addr_q, addr_d;

  bf_addr_t      nxt_k;
  bf_addr_t      nxt_s;
  bf_addr_t      first;
  wb_t           dl_in;
  wb_t           dl_out;
  logic          pend;

  assign nxt_k = bf_addr(stage_q, k_q + KW'(1));
  assign nxt_s = bf_addr(stage_q + SW'(1), KW'(0));
  assign first = bf_addr(SW'(0), KW'(0));

  // k_q indexes the butterfly currently held in addr_q/bfv_q.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = done_q;
    bfv_d   = bfv_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          stage_d = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          bfv_d   = 1'b1;
          addr_d  = first;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (k_q == KW'(N / 2 - 1)) begin
            state_d = S_BARRIER;
            bfv_d   = 1'b0;
          end else begin
            k_d    = k_q + KW'(1);
            addr_d = nxt_k;
          end
        end
      end
      S_BARRIER: begin
        if (!stall && !pend) begin
          if (stage_q == SW'(LOG_N - 1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            stage_d = stage_q + SW'(1);
            k_d     = '0;
            bfv_d   = 1'b1;
            addr_d  = nxt_s;
          end
        end
      end
      S_DONE: begin
        if (!stall) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bfv_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bfv_q   <= bfv_d;
      addr_q  <= addr_d;
    end
  end

  assign dl_in = {bfv_q, addr_q.a, addr_q.b};

  ntt_delay_line #(
    .W     ($bits(wb_t)),
    .DEPTH (LAT)
  ) u_dl (
    .clk        (clk),
    .rst        (rst),
    .en         (!stall),
    .in_d       (dl_in),
    .out_q      (dl_out),
    .pend_valid (pend)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign bf_valid  = bfv_q & ~stall;
  assign rd_addr_a = addr_q.a;
  assign rd_addr_b = addr_q.b;
  assign tw_addr   = addr_q.tw;
  assign stage     = stage_q;
  assign wb_valid  = dl_out.vld & ~stall;
  assign wr_addr_a = dl_out.a;
  assign wr_addr_b = dl_out.b;

endmodule

// File: tb/tb_intt_stage_scheduler.sv
// Randomised-stall scoreboard bench for intt_stage_scheduler at LAT=3, 1 and 7,
// with a RAM-hazard model and an abstract per-stage issue/write-back timeline.
module tb_intt_stage_scheduler;

  localparam int NI = 3;
  localparam int LATS [NI] = '{3, 1, 7};

  typedef struct {
    int a;
    int b;
    int tw;
    int s;
    int t;
  } iss_t;

  typedef struct {
    int a;
    int b;
    int t;
  } wbe_t;

  logic clk;
  logic rst;
  logic start;
  logic stall;

  logic [NI-1:0]      busy;
  logic [NI-1:0]      done;
  logic [NI-1:0]      bfv;
  logic [NI-1:0]      wbv;
  logic [NI-1:0][3:0] ra;
  logic [NI-1:0][3:0] rb;
  logic [NI-1:0][3:0] twa;
  logic [NI-1:0][1:0] stg;
  logic [NI-1:0][3:0] wa;
  logic [NI-1:0][3:0] wbb;

  iss_t exp_iss [NI][$];
  wbe_t exp_wb  [NI][$];
  int   pend    [NI][16];
  int   hist    [NI][16];
  int   done_seen [NI];
  int   done_t    [NI];

  int   n_chk;
  int   n_fail;
  int   act;
  bit   act_on;
  iss_t mi;
  wbe_t mw;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    intt_stage_scheduler #(.LAT(LATS[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stall     (stall),
      .busy      (busy[g]),
      .done      (done[g]),
      .bf_valid  (bfv[g]),
      .rd_addr_a (ra[g]),
      .rd_addr_b (rb[g]),
      .tw_addr   (twa[g]),
      .stage     (stg[g]),
      .wb_valid  (wbv[g]),
      .wr_addr_a (wa[g]),
      .wr_addr_b (wbb[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int g,
                              input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s lat=%0d got=%0d exp=%0d t=%0t",
               nm, LATS[g], got, exp, $time);
    end
  endfunction

  function automatic int hist_exp(input int tw);
    if (tw >= 8) return 1;
    if (tw >= 4) return 2;
    if (tw >= 2) return 4;
    if (tw == 1) return 8;
    return 0;
  endfunction

  function automatic int outs(input int g);
    return int'({busy[g], done[g], bfv[g], wbv[g], ra[g], rb[g],
                 twa[g], stg[g], wa[g], wbb[g]});
  endfunction

  function automatic bit all_done();
    for (int g = 0; g < NI; g++) begin
      if (done_seen[g] == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void flush();
    for (int g = 0; g < NI; g++) begin
      exp_iss[g].delete();
      exp_wb[g].delete();
      for (int x = 0; x < 16; x++) begin
        pend[g][x] = 0;
        hist[g][x] = 0;
      end
    end
  endfunction

  // Expected transform schedule from the stage/block/offset definition.
  function automatic void load_model();
    int t, h, j, tt;
    flush();
    for (int g = 0; g < NI; g++) begin
      done_seen[g] = 0;
      done_t[g]    = 4 * (8 + LATS[g]) + 1;
      for (int s = 0; s < 4; s++) begin
        t = 1 << s;
        h = 16 >> (s + 1);
        for (int i = 0; i < (8 >> s); i++) begin
          for (int off = 0; off < t; off++) begin
            j  = i * 2 * t + off;
            tt = 1 + s * (8 + LATS[g]) + i * t + off;
            exp_iss[g].push_back('{j, j + t, h + i, s, tt});
            exp_wb[g].push_back('{j, j + t, tt + LATS[g]});
          end
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (act_on && !stall) act++;
      for (int g = 0; g < NI; g++) begin
        if (stall) begin
          chk("bf_gate", g, int'(bfv[g]), 0);
          chk("wb_gate", g, int'(wbv[g]), 0);
        end
        if (bfv[g]) begin
          if (exp_iss[g].size() == 0) begin
            chk("bf_count", g, int'(bfv[g]), 0);
          end else begin
            mi = exp_iss[g].pop_front();
            chk("rd_a", g, int'(ra[g]), mi.a);
            chk("rd_b", g, int'(rb[g]), mi.b);
            chk("tw", g, int'(twa[g]), mi.tw);
            chk("stage", g, int'(stg[g]), mi.s);
            chk("iss_time", g, act, mi.t);
            chk("busy", g, int'(busy[g]), 1);
            chk("raw_a", g, pend[g][ra[g]], 0);
            chk("raw_b", g, pend[g][rb[g]], 0);
            pend[g][mi.a]++;
            pend[g][mi.b]++;
            hist[g][mi.tw]++;
          end
        end
        if (wbv[g]) begin
          if (exp_wb[g].size() == 0) begin
            chk("wb_count", g, int'(wbv[g]), 0);
          end else begin
            mw = exp_wb[g].pop_front();
            chk("wr_a", g, int'(wa[g]), mw.a);
            chk("wr_b", g, int'(wbb[g]), mw.b);
            chk("wb_time", g, act, mw.t);
            pend[g][mw.a]--;
            pend[g][mw.b]--;
          end
        end
        if (done[g] && !stall && act_on) begin
          done_seen[g]++;
          chk("done_time", g, act, done_t[g]);
          chk("busy_at_done", g, int'(busy[g]), 0);
          chk("iss_pending", g, exp_iss[g].size(), 0);
          chk("wb_pending", g, exp_wb[g].size(), 0);
          for (int x = 0; x < 16; x++) begin
            chk($sformatf("tw_hist%0d", x), g, hist[g][x], hist_exp(x));
          end
        end
      end
    end
  end

  task automatic run_job(input int re_st, input int st_at, input int st_len,
                         input int rst_at, input int rnd, input bit st0);
    bit aborted;
    aborted = 1'b0;
    @(posedge clk); #1;
    load_model();
    start = 1'b1;
    stall = st0;
    @(posedge clk); #1;
    start  = 1'b0;
    act    = 0;
    act_on = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      if (all_done()) break;
      stall = (st0 && c <= 3) || (c >= st_at && c < st_at + st_len) ||
              (rnd > 0 && $urandom_range(99) < rnd);
      start = (c == re_st);
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        for (int g = 0; g < NI; g++) begin
          chk("abort_zero", g, outs(g), 0);
          chk("abort_no_done", g, done_seen[g], 0);
        end
        flush();
        act_on  = 1'b0;
        stall   = 1'b0;
        start   = 1'b0;
        aborted = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    start = 1'b0;
    if (!aborted) begin
      for (int g = 0; g < NI; g++) begin
        chk("done_count", g, done_seen[g], 1);
        chk("iss_left", g, exp_iss[g].size(), 0);
        chk("wb_left", g, exp_wb[g].size(), 0);
      end
    end
    act_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    act    = 0;
    act_on = 1'b0;
    rst    = 1'b1;
    start  = 1'b0;
    stall  = 1'b0;
    for (int g = 0; g < NI; g++) done_seen[g] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) chk("reset_zero", g, outs(g), 0);
    rst = 1'b0;
    run_job(10, 0, 0, 0, 0, 1'b0);
    run_job(0, 25, 5, 0, 0, 1'b0);
    run_job(0, 0, 0, 20, 0, 1'b0);
    run_job(0, 0, 0, 0, 0, 1'b0);
    repeat (3) run_job(0, 0, 0, 0, 25, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
